// File: rtl/im_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// im_fetch_arbiter
//
// Round-robin arbiter that shares one single-port instruction memory among
// N_CORES cores. Core fetch requests (imr + PC) are serialised into memory
// reads. The fetched word is broadcast on ir_data, and a one-cycle one-hot
// ir_valid strobe marks the owning core. A core that has raised finish is
// excluded from arbitration.
//
// Parameters
//   N_CORES  number of requesting cores (2..8)
//   AW       PC / memory address width
//   DW       instruction word width
//   MEM_LAT  memory read latency, im_rd -> im_data valid (1..4)
//
// Ports
//   clk       in   1            clock, all logic on posedge
//   rst       in   1            synchronous active-high reset
//   imr       in   N_CORES      per-core fetch request, held until own ir_valid
//   pc_bus    in   N_CORES*AW   core k PC at [k*AW +: AW]
//   finish    in   N_CORES      core k done, masks imr[k]
//   im_data   in   DW           instruction memory read data
//   stat_sel  in   3            grant counter select      (IMARB_STATS_EN only)
//   stat_cnt  out  16           selected grant count, reg (IMARB_STATS_EN only)
//   im_rd     out  1            memory read enable
//   im_addr   out  AW           memory read address
//   ir_data   out  DW           fetched word, broadcast to all cores
//   ir_valid  out  N_CORES      one-hot owner strobe for ir_data
//   busy      out  1            transaction in flight
//   all_done  out  1            registered AND of finish
//
// Build option
//   IMARB_STATS_EN  adds per-core 16-bit grant counters and the stat_sel /
//                   stat_cnt read port. Undefined: ports and counters absent.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module im_fetch_arbiter #(
    parameter int N_CORES = 8,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CORES-1:0]    imr,
    input  logic [N_CORES*AW-1:0] pc_bus,
    input  logic [N_CORES-1:0]    finish,
    input  logic [DW-1:0]         im_data,
`ifdef IMARB_STATS_EN
    input  logic [2:0]            stat_sel,
    output logic [15:0]           stat_cnt,
`endif
    output logic                  im_rd,
    output logic [AW-1:0]         im_addr,
    output logic [DW-1:0]         ir_data,
    output logic [N_CORES-1:0]    ir_valid,
    output logic                  busy,
    output logic                  all_done
);

    localparam int unsigned NC    = N_CORES;
    localparam int          PTR_W = $clog2(N_CORES);
    localparam int          LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [PTR_W-1:0] LAST_CORE = PTR_W'(N_CORES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant;
    logic [LAT_W-1:0]   lat_cnt;

    logic [N_CORES-1:0] eligible;
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    int unsigned        scan_idx;
    logic [AW-1:0]      pc_arr [N_CORES];

    // Unpack the flat PC bus so the granted PC can be selected by index.
    always_comb begin
        for (int unsigned k = 0; k < NC; k++) begin
            pc_arr[k] = pc_bus[k*AW +: AW];
        end
    end

    assign eligible = imr & ~finish;

    // Round-robin search: first eligible core at or above rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int unsigned i = 0; i < NC; i++) begin
            scan_idx = (32'(rr_ptr) + i) % NC;
            if (!pick_found && eligible[PTR_W'(scan_idx)]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(scan_idx);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (pick_found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (lat_cnt == '0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        im_rd    = (state == S_ISSUE);
        busy     = (state != S_IDLE);
        ir_valid = '0;
        if (state == S_RESP) begin
            ir_valid[grant] = 1'b1;
        end
    end

    // Grant and address are registered together when leaving IDLE, so
    // im_addr already carries the granted PC throughout ISSUE and holds
    // it until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            lat_cnt  <= '0;
            im_addr  <= '0;
            ir_data  <= '0;
            all_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            all_done <= &finish;
            unique case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant   <= pick_idx;
                        im_addr <= pc_arr[pick_idx];
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= LAT_W'(MEM_LAT - 1);
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        ir_data <= im_data;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    rr_ptr <= (grant == LAST_CORE) ? '0 : grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef IMARB_STATS_EN
    logic [15:0] grant_cnt [N_CORES];
    logic [15:0] sel_cnt;

    // Selects beyond the last core fall through to zero.
    always_comb begin
        sel_cnt = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (stat_sel == 3'(i)) sel_cnt = grant_cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NC; i++) begin
                grant_cnt[i] <= '0;
            end
            stat_cnt <= '0;
        end else begin
            if (state == S_RESP) begin
                grant_cnt[grant] <= grant_cnt[grant] + 16'd1;
            end
            stat_cnt <= sel_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_im_fetch_arbiter.sv
`timescale 1ns/1ps

module tb_im_fetch_arbiter;

    localparam int N   = 8;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      imr;
    logic [N*AW-1:0]   pc_bus;
    logic [N-1:0]      finish;
    logic [DW-1:0]     im_data;
    logic              im_rd;
    logic [AW-1:0]     im_addr;
    logic [DW-1:0]     ir_data;
    logic [N-1:0]      ir_valid;
    logic              busy;
    logic              all_done;
`ifdef IMARB_STATS_EN
    logic [2:0]        stat_sel;
    logic [15:0]       stat_cnt;
`endif

    im_fetch_arbiter #(
        .N_CORES (N),
        .AW      (AW),
        .DW      (DW),
        .MEM_LAT (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .imr      (imr),
        .pc_bus   (pc_bus),
        .finish   (finish),
        .im_data  (im_data),
`ifdef IMARB_STATS_EN
        .stat_sel (stat_sel),
        .stat_cnt (stat_cnt),
`endif
        .im_rd    (im_rd),
        .im_addr  (im_addr),
        .ir_data  (ir_data),
        .ir_valid (ir_valid),
        .busy     (busy),
        .all_done (all_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int            core;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   prev_rd    = -1;
    int   last_rd    = -1;
    bit   period_chk = 1'b0;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return a ^ 16'hABDD;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int core, input logic [AW-1:0] addr);
        exp_t e;
        e.core = core;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input int core);
        int n;
        n = 0;
        while (ir_valid[core] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check($sformatf("valid_timeout_core%0d", core), 64'(n < 40), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_im_rd"},    64'(im_rd),    64'd0);
        check({tag, "_im_addr"},  64'(im_addr),  64'd0);
        check({tag, "_ir_data"},  64'(ir_data),  64'd0);
        check({tag, "_ir_valid"}, 64'(ir_valid), 64'd0);
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_all_done"}, 64'(all_done), 64'd0);
    endtask

    // Memory model: returns memf(addr) exactly LAT cycles after im_rd,
    // junk otherwise, so a mistimed capture shows up in ir_data.
    logic [DW-1:0] mem_pipe [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) mem_pipe[i] <= mem_pipe[i-1];
        mem_pipe[0] <= im_rd ? memf(im_addr) : 16'h5555;
    end
    assign im_data = mem_pipe[LAT-1];

    always @(posedge clk) cyc++;

    // Scoreboard monitor: reads checked against the queue head, responses pop it.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            exp_q.delete();
            prev_rd = -1;
        end else begin
            if (im_rd === 1'b1) begin
                check("rd_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) check("im_addr", 64'(im_addr), 64'(exp_q[0].addr));
                if (period_chk && prev_rd >= 0) check("grant_period", 64'(cyc - prev_rd), 64'(LAT + 3));
                prev_rd = cyc;
                last_rd = cyc;
            end
            if (ir_valid !== '0) begin
                check("valid_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    check("ir_valid", 64'(ir_valid), 64'(N'(1) << cur.core));
                    check("ir_data", 64'(ir_data), 64'(memf(cur.addr)));
                    check("rd_to_valid", 64'(cyc - last_rd), 64'(LAT + 1));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        imr    = '0;
        finish = '0;
        for (int k = 0; k < N; k++) pc_bus[k*AW +: AW] = AW'(k);
`ifdef IMARB_STATS_EN
        stat_sel = 3'd0;
`endif
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single request from core 3.
        pc_bus[3*AW +: AW] = 16'h0010;
        imr = 8'h08;
        push(3, 16'h0010);
        step();
        check("t1_im_rd", 64'(im_rd), 64'd1);
        check("t1_addr", 64'(im_addr), 64'h0010);
        check("t1_busy", 64'(busy), 64'd1);
        step();
        check("t1_wait_rd", 64'(im_rd), 64'd0);
        check("t1_wait_valid", 64'(ir_valid), 64'd0);
        check("t1_addr_hold", 64'(im_addr), 64'h0010);
        step();
        check("t1_valid", 64'(ir_valid), 64'h08);
        check("t1_data", 64'(ir_data), 64'hABCD);
        imr = '0;
        step();
        check("t1_valid_off", 64'(ir_valid), 64'd0);
        check("t1_data_hold", 64'(ir_data), 64'hABCD);
        check("t1_idle", 64'(busy), 64'd0);
        pc_bus[3*AW +: AW] = 16'h0003;

        // All cores requesting continuously from a fresh rr_ptr.
        rst = 1'b1;
        step();
        rst = 1'b0;
        period_chk = 1'b1;
        imr = 8'hFF;
        for (int k = 0; k < 9; k++) push(k % N, AW'(k % N));
        repeat (35) step();
        check("t2_ninth_grant", 64'(ir_valid), 64'h01);
        imr = '0;
        step();
        step();
        period_chk = 1'b0;
        check("t2_drained", 64'(exp_q.size()), 64'd0);
        check("t2_idle", 64'(busy), 64'd0);

        // Core 6 grant leaves rr_ptr at 7: core 7 beats core 0.
        imr = 8'h40;
        push(6, 16'h0006);
        wait_valid(6);
        imr = 8'h81;
        push(7, 16'h0007);
        push(0, 16'h0000);
        wait_valid(7);
        imr = 8'h01;
        step();
        wait_valid(0);
        imr = '0;
        step();

        // imr drop and finish rise mid-transaction still complete it.
        imr = 8'h02;
        push(1, 16'h0001);
        step();
        imr    = '0;
        finish = 8'h02;
        wait_valid(1);
        finish = '0;
        step();
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // Finished core is masked; all_done lags finish by one cycle.
        finish = 8'h04;
        imr    = 8'h04;
        repeat (6) begin
            step();
            check("t4_no_rd", 64'(im_rd), 64'd0);
            check("t4_not_busy", 64'(busy), 64'd0);
        end
        check("t4_not_done", 64'(all_done), 64'd0);
        finish = 8'hFF;
        check("t4_done_lag", 64'(all_done), 64'd0);
        step();
        check("t4_done", 64'(all_done), 64'd1);
        finish = '0;
        imr    = '0;
        step();
        check("t4_done_clear", 64'(all_done), 64'd0);

        // Reset during WAIT aborts; afterwards rr_ptr=0 favours core 0.
        imr = 8'h21;
        push(5, 16'h0005);
        step();
        step();
        check("t5_in_wait", 64'(busy & ~im_rd), 64'd1);
        rst = 1'b1;
        step();
        check_reset_outputs("t5_abort");
        step();
        check("t5_no_valid", 64'(ir_valid), 64'd0);
        rst = 1'b0;
        push(0, 16'h0000);
        push(5, 16'h0005);
        wait_valid(0);
        imr = 8'h20;
        step();
        wait_valid(5);
        imr = '0;
        step();
        step();
        check("t5_drained", 64'(exp_q.size()), 64'd0);

`ifdef IMARB_STATS_EN
        // Grant counters: three grants to core 2, none to core 5.
        rst = 1'b1;
        step();
        rst = 1'b0;
        stat_sel = 3'd2;
        imr = 8'h04;
        for (int k = 0; k < 3; k++) push(2, 16'h0002);
        wait_valid(2);
        step();
        wait_valid(2);
        step();
        wait_valid(2);
        imr = '0;
        step();
        step();
        check("t6_cnt2", 64'(stat_cnt), 64'd3);
        stat_sel = 3'd5;
        step();
        check("t6_cnt5", 64'(stat_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
